// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: merges ALU (A) and memory (M) writeback requests onto
// the single regfile write port through two small FIFOs and a round-robin
// scheduler, and publishes a mask of registers with writes still pending.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data ALU requester push handshake
//   m_valid/m_ready/m_addr/m_data memory requester push handshake
//   hold                          suppress granting this cycle
//   rf_we/rf_wa/rf_wd             registered regfile write port
//   busy_mask                     bit i = write to reg i queued or in flight

module rf_wr_fifo #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic [AW-1:0]       in_addr,
    input  logic [DW-1:0]       in_data,
    input  logic                pop,
    output logic                ready,
    output logic                nempty,
    output logic [AW-1:0]       head_addr,
    output logic [DW-1:0]       head_data,
    output logic [(1<<AW)-1:0]  mask
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW = 1 << AW;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;

    // ready is a function of occupancy alone: a full FIFO never takes a
    // push, even when it is being drained on the same edge.
    assign ready     = (count != CW'(DEPTH));
    assign nempty    = (count != '0);
    assign do_push   = push && ready;
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Slot j holds a live entry if it lies in [rd_ptr, wr_ptr) circularly.
    function automatic logic slot_live(input int j);
        int r;
        int w;
        r = int'(rd_ptr);
        w = int'(wr_ptr);
        if (count == CW'(DEPTH)) return 1'b1;
        if (w > r) return (j >= r) && (j < w);
        if (w < r) return (j >= r) || (j < w);
        return 1'b0;
    endfunction

    always_comb begin
        mask = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (slot_live(j)) mask = mask | (MW'(1) << addr_q[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (pop)     rd_ptr <= nxt(rd_ptr);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
        end
    end
endmodule

module rf_wr_arbiter #(
    parameter int DW    = 8,
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [AW-1:0]       a_addr,
    input  logic [DW-1:0]       a_data,
    input  logic                m_valid,
    output logic                m_ready,
    input  logic [AW-1:0]       m_addr,
    input  logic [DW-1:0]       m_data,
    input  logic                hold,
    output logic                rf_we,
    output logic [AW-1:0]       rf_wa,
    output logic [DW-1:0]       rf_wd,
    output logic [(1<<AW)-1:0]  busy_mask
);
    localparam int MW = 1 << AW;

    logic          a_nempty;
    logic          m_nempty;
    logic [AW-1:0] a_head_addr;
    logic [AW-1:0] m_head_addr;
    logic [DW-1:0] a_head_data;
    logic [DW-1:0] m_head_data;
    logic [MW-1:0] a_mask;
    logic [MW-1:0] m_mask;
    logic          last_m;
    logic          gnt_a;
    logic          gnt_m;

    rf_wr_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rstn      (rstn),
        .push      (a_valid),
        .in_addr   (a_addr),
        .in_data   (a_data),
        .pop       (gnt_a),
        .ready     (a_ready),
        .nempty    (a_nempty),
        .head_addr (a_head_addr),
        .head_data (a_head_data),
        .mask      (a_mask)
    );

    rf_wr_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo_m (
        .clk       (clk),
        .rstn      (rstn),
        .push      (m_valid),
        .in_addr   (m_addr),
        .in_data   (m_data),
        .pop       (gnt_m),
        .ready     (m_ready),
        .nempty    (m_nempty),
        .head_addr (m_head_addr),
        .head_data (m_head_data),
        .mask      (m_mask)
    );

    // On a tie the requester that did not win last time goes next.
    assign gnt_a = !hold && a_nempty && (!m_nempty || last_m);
    assign gnt_m = !hold && m_nempty && (!a_nempty || !last_m);

    assign busy_mask = a_mask | m_mask |
                       (rf_we ? (MW'(1) << rf_wa) : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            last_m <= 1'b1;
        end else begin
            rf_we <= gnt_a || gnt_m;
            if (gnt_a) begin
                rf_wa  <= a_head_addr;
                rf_wd  <= a_head_data;
                last_m <= 1'b0;
            end else if (gnt_m) begin
                rf_wa  <= m_head_addr;
                rf_wd  <= m_head_data;
                last_m <= 1'b1;
            end
        end
    end
endmodule
